fm_demod_stream: RTL and testbench
==================================

# fm_demod_stream

Parametrised, packet-aware FM demodulation pipeline: complex I/Q samples in, instantaneous-frequency samples out. It combines packet framing, a conjugate-product phase discriminator and a power-of-two moving average behind a valid-qualified stream interface. It replaces the fixed 16-bit, 128-tap chain at the top of the receive path. It adds sample gaps, packet-end detection, configurable averaging depth and saturating output scaling.

## Interface
- `WIDTH`, 16: bits per I and per Q component and per output sample.
- `AVG_LOG2`, 7: moving-average depth is 2^AVG_LOG2. A value of 0 bypasses the averager.
- `IDLE_LEN`, 8: number of consecutive valid all-zero samples that terminate a packet.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `data_i`, in, 2*WIDTH: signed; I in [2W-1:W], Q in [W-1:0].
- `valid_i`, in, 1: `data_i` carries a sample this cycle. No backpressure.
- `data_o`, out, WIDTH: signed demodulated sample.
- `valid_o`, out, 1: `data_o` is new this cycle.
- `pkt_start_o`, out, 1: one-cycle pulse marking the first sample of a packet.
- `pkt_end_o`, out, 1: one-cycle pulse marking the terminating sample of a packet.

## Operation
- **Packet FSM states:** IDLE, FILL, RUN.
- **IDLE:**
  - Valid samples equal to 0 are discarded.
  - The first valid nonzero sample starts a packet and moves the FSM to FILL.
  - At packet start: previous-sample register = 0, averager history and sum = 0, fill counter = 0, zero-run counter = 0.
- **FILL:**
  - Counts valid samples.
  - On the 2^AVG_LOG2-th valid sample of the packet, move to RUN. With AVG_LOG2=0, the first sample goes straight to RUN.
- **RUN:** every valid sample produces one `valid_o`.
- **Zero-run counter (FILL and RUN):**
  - Increments on each valid zero sample; clears on any valid nonzero sample.
  - When it reaches IDLE_LEN, that sample is processed normally, `pkt_end_o` is tagged and the FSM moves to IDLE.
  - An end in FILL produces `pkt_end_o` with no `valid_o`.
- **Discriminator:**
  - d[n] = I[n-1]·Q[n] − I[n]·Q[n-1], full precision 2W+1 bits.
  - Arithmetic shift right by W−1, then saturate to the range [−2^(W−1), 2^(W−1)−1].
  - For the first sample of a packet, x[n-1]=0, so d=0.
- **Averager:**
  - Circular buffer of 2^AVG_LOG2 words of W bits, plus a running sum of W+AVG_LOG2 bits.
  - Each valid sample: sum += d_new − d_oldest.
  - Output = sum >>> AVG_LOG2 (floor).
- **Idle cycles:** `data_o` holds its last value while `valid_o`=0.

## Timing
- **Latency:** fixed 3 cycles from a `valid_i` cycle to the corresponding `valid_o`, `pkt_start_o` or `pkt_end_o`, independent of gaps.
  - Stage 1: products.
  - Stage 2: sum, shift and saturate.
  - Stage 3: average.
- **Stream rules:**
  - Pipeline stages carry a valid tag every cycle.
  - The averager and counters update only on tagged-valid samples.
  - Back-to-back `valid_i` sustains 1 output per cycle.
- **Flag alignment:**
  - `pkt_start_o` and `valid_o` may be coincident (AVG_LOG2=0).
  - `pkt_end_o` and `valid_o` are coincident when the end occurs in RUN.
- **Reset:**
  - All outputs are 0 in the cycle after `rst` is sampled high. FSM = IDLE; all counters, buffer pointer and sum = 0.
  - In-flight samples are dropped; no pulse emerges after reset.
  - Reset mid-packet produces no `pkt_end_o`.
- **New packet during drain:** a new packet may start on the sample immediately after a terminating sample. Its `pkt_start_o` follows `pkt_end_o` by 1 cycle.

## Structure
- **Shared package `fm_demod_pkg`:**
  - FSM state encoding (IDLE/FILL/RUN).
  - Saturating shift-and-clip function, parameterised by input width and output width.
  - I/Q field slice constants.
- **Sub-module `moving_avg_pow2`** (WIDTH, AVG_LOG2):
  - Ports: clk, rst, clr_i, valid_i, data_i, data_o, valid_o.
  - Holds the buffer and running sum.
  - clr_i has priority over valid_i in the same cycle.
- The discriminator and FSM live in `fm_demod_stream`.

## Test plan
Defaults for all tests unless stated: WIDTH=16, AVG_LOG2=2, IDLE_LEN=4.
1. **Constant-phase tone:** 8 back-to-back samples (16384,0).
   - `pkt_start_o` 3 cycles after sample 1.
   - `valid_o` first 3 cycles after sample 4, data_o=0 for 5 outputs.
2. **+90° rotation:** samples (16384,0),(0,16384),(−16384,0),(0,−16384), repeated.
   - d = 0, 8192, 8192, …
   - data_o = 6144 on the first output, then 8192.
3. **Saturation (AVG_LOG2=0):** (−32768,0) then (0,−32768).
   - Second output = 32767 (unsaturated result 32768).
   - First output = 0, coincident with `pkt_start_o`.
4. **Packet end and restart:** after test 2, send 4 zero samples, then one zero sample, then (16384,0).
   - `pkt_end_o` pulses once, 3 cycles after the 4th zero sample.
   - The 5th zero sample is ignored.
   - `pkt_start_o` for (16384,0); the averager restarts from an empty history (no stale 8192 contributes).
5. **Gapped input:** test 2 stimulus with `valid_i` alternating 1/0.
   - Identical data_o sequence; `valid_o` spaced 2 cycles apart.
6. **Reset mid-packet:** assert `rst` for 1 cycle during RUN.
   - Outputs are 0 the next cycle.
   - No `valid_o`/`pkt_end_o` from in-flight samples.
   - The next nonzero sample gives `pkt_start_o` and a first output of 0.

Source files
------------

// File: rtl/fm_demod_stream_pkg.sv
// fm_demod_pkg: shared definitions for the FM demodulation stream.
//   state_t    - packet FSM encoding (IDLE / FILL / RUN)
//   IQ_*_IDX   - element index of I and Q when a sample is viewed as [1:0][WIDTH-1:0]
//   sat_shift  - arithmetic shift right followed by clipping to a signed output width
package fm_demod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // I occupies the upper half of a sample word, Q the lower half.
    localparam int IQ_I_IDX = 1;
    localparam int IQ_Q_IDX = 0;

    localparam int SAT_MAX_W = 64;

    // x holds a signed value of in_w bits (upper bits are ignored and re-derived
    // from bit in_w-1). The result is x >>> shift, clipped to the out_w-bit
    // signed range and returned sign-extended to SAT_MAX_W bits.
    function automatic logic signed [SAT_MAX_W-1:0] sat_shift(
        input logic signed [SAT_MAX_W-1:0] x,
        input int                          in_w,
        input int                          shift,
        input int                          out_w
    );
        logic signed [SAT_MAX_W-1:0] one;
        logic signed [SAT_MAX_W-1:0] ext;
        logic signed [SAT_MAX_W-1:0] shr;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        one = SAT_MAX_W'(1);
        ext = (x <<< (SAT_MAX_W - in_w)) >>> (SAT_MAX_W - in_w);
        shr = ext >>> shift;
        hi  = (one <<< (out_w - 1)) - one;
        lo  = -hi - one;
        if (shr > hi) begin
            return hi;
        end
        if (shr < lo) begin
            return lo;
        end
        return shr;
    endfunction

endpackage

// File: rtl/fm_demod_stream_if.sv
// fm_demod_stream_if: sample stream bundle for fm_demod_stream.
//   data_i      - packed I/Q sample, I in [2W-1:W], Q in [W-1:0]
//   valid_i     - data_i carries a sample this cycle (no backpressure)
//   data_o      - demodulated sample
//   valid_o     - data_o is new this cycle
//   pkt_start_o - first sample of a packet
//   pkt_end_o   - terminating sample of a packet
// master drives the input side, slave is the demodulator.
interface fm_demod_stream_if #(
    parameter int WIDTH = 16
);
    logic [2*WIDTH-1:0] data_i;
    logic               valid_i;
    logic [WIDTH-1:0]   data_o;
    logic               valid_o;
    logic               pkt_start_o;
    logic               pkt_end_o;

    modport master (
        output data_i, valid_i,
        input  data_o, valid_o, pkt_start_o, pkt_end_o
    );

    modport slave (
        input  data_i, valid_i,
        output data_o, valid_o, pkt_start_o, pkt_end_o
    );
endinterface

// File: rtl/fm_demod_stream_moving_avg_pow2.sv
// moving_avg_pow2: running mean over the last 2^AVG_LOG2 valid samples.
//   clk, rst - clock and synchronous active-high reset
//   clr_i    - empty the history and sum (wins over valid_i)
//   valid_i  - data_i is a sample to add to the window
//   data_i   - signed sample
//   data_o   - floor(sum / 2^AVG_LOG2), registered
//   valid_o  - valid_i delayed by one cycle
// AVG_LOG2 = 0 degenerates to a plain register.
module moving_avg_pow2 #(
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] data_i,
    output logic signed [WIDTH-1:0] data_o,
    output logic                    valid_o
);

    logic valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    assign valid_o = valid_q;

    generate
        if (AVG_LOG2 == 0) begin : g_bypass
            logic signed [WIDTH-1:0] avg_q;
            logic signed [WIDTH-1:0] avg_d;

            always_comb begin
                avg_d = avg_q;
                if (clr_i) begin
                    avg_d = '0;
                end else if (valid_i) begin
                    avg_d = data_i;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    avg_q <= '0;
                end else begin
                    avg_q <= avg_d;
                end
            end

            assign data_o = avg_q;
        end else begin : g_avg
            localparam int DEPTH = 1 << AVG_LOG2;
            localparam int SW    = WIDTH + AVG_LOG2;

            logic signed [WIDTH-1:0] buf_q [DEPTH];
            logic signed [WIDTH-1:0] buf_d [DEPTH];
            logic [AVG_LOG2-1:0]     ptr_q;
            logic [AVG_LOG2-1:0]     ptr_d;
            logic signed [SW-1:0]    sum_q;
            logic signed [SW-1:0]    sum_d;
            logic signed [WIDTH-1:0] avg_q;
            logic signed [WIDTH-1:0] avg_d;

            // ptr_q points at the oldest entry; it is overwritten by the new
            // sample while the same entry is subtracted from the running sum.
            always_comb begin
                buf_d = buf_q;
                ptr_d = ptr_q;
                sum_d = sum_q;
                avg_d = avg_q;
                if (clr_i) begin
                    buf_d = '{default: '0};
                    ptr_d = '0;
                    sum_d = '0;
                    avg_d = '0;
                end else if (valid_i) begin
                    sum_d        = sum_q + SW'(data_i) - SW'(buf_q[ptr_q]);
                    buf_d[ptr_q] = data_i;
                    ptr_d        = ptr_q + AVG_LOG2'(1);
                    avg_d        = sum_d[SW-1:AVG_LOG2];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_q <= '{default: '0};
                    ptr_q <= '0;
                    sum_q <= '0;
                    avg_q <= '0;
                end else begin
                    buf_q <= buf_d;
                    ptr_q <= ptr_d;
                    sum_q <= sum_d;
                    avg_q <= avg_d;
                end
            end

            assign data_o = avg_q;
        end
    endgenerate

endmodule

// File: rtl/fm_demod_stream.sv
// fm_demod_stream: packet-aware FM demodulator, I/Q in, instantaneous frequency out.
//   clk, rst - clock and synchronous active-high reset
//   bus      - fm_demod_stream_if slave port (samples in, demodulated stream and
//              packet start/end pulses out)
// Pipeline: stage 1 products, stage 2 difference/shift/saturate, stage 3 average.
// Every input sample reaches the outputs exactly three cycles later.
module fm_demod_stream
    import fm_demod_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 7,
    parameter int IDLE_LEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    fm_demod_stream_if.slave bus
);

    localparam int PROD_W   = 2 * WIDTH;
    localparam int DIFF_W   = 2 * WIDTH + 1;
    localparam int FILL_LEN = 1 << AVG_LOG2;
    localparam int FILL_W   = AVG_LOG2 + 1;
    localparam int ZERO_W   = $clog2(IDLE_LEN + 1);

    logic [1:0][WIDTH-1:0]   iq;
    logic signed [WIDTH-1:0] cur_i;
    logic signed [WIDTH-1:0] cur_q;
    logic                    is_zero;

    assign iq      = bus.data_i;
    assign cur_i   = signed'(iq[IQ_I_IDX]);
    assign cur_q   = signed'(iq[IQ_Q_IDX]);
    assign is_zero = (bus.data_i == '0);

    state_t                  state_q, state_d;
    logic [FILL_W-1:0]       fill_cnt_q, fill_cnt_d;
    logic [ZERO_W-1:0]       zero_cnt_q, zero_cnt_d;
    logic signed [WIDTH-1:0] prev_i_q, prev_i_d;
    logic signed [WIDTH-1:0] prev_q_q, prev_q_d;

    logic                    take;
    logic                    start;
    logic                    fin;
    logic                    out_en;
    logic signed [WIDTH-1:0] op_i;
    logic signed [WIDTH-1:0] op_q;

    // Packet FSM. The sample that starts a packet counts as the first fill
    // sample and is paired with a zero previous sample, so its discriminator
    // output is zero. An end reached while still filling emits no output.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        zero_cnt_d = zero_cnt_q;
        prev_i_d   = prev_i_q;
        prev_q_d   = prev_q_q;
        take       = 1'b0;
        start      = 1'b0;
        fin        = 1'b0;
        out_en     = 1'b0;
        op_i       = prev_i_q;
        op_q       = prev_q_q;
        if (bus.valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (!is_zero) begin
                        take       = 1'b1;
                        start      = 1'b1;
                        op_i       = '0;
                        op_q       = '0;
                        zero_cnt_d = '0;
                        if (FILL_LEN == 1) begin
                            state_d    = ST_RUN;
                            fill_cnt_d = '0;
                            out_en     = 1'b1;
                        end else begin
                            state_d    = ST_FILL;
                            fill_cnt_d = FILL_W'(1);
                        end
                    end
                end
                ST_FILL, ST_RUN: begin
                    take = 1'b1;
                    if (state_q == ST_RUN) begin
                        out_en = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                        if (fill_cnt_q == FILL_W'(FILL_LEN - 1)) begin
                            state_d = ST_RUN;
                            out_en  = 1'b1;
                        end
                    end
                    if (is_zero) begin
                        if (zero_cnt_q == ZERO_W'(IDLE_LEN - 1)) begin
                            fin        = 1'b1;
                            state_d    = ST_IDLE;
                            zero_cnt_d = '0;
                            if (state_q == ST_FILL) begin
                                out_en = 1'b0;
                            end
                        end else begin
                            zero_cnt_d = zero_cnt_q + ZERO_W'(1);
                        end
                    end else begin
                        zero_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (take) begin
                prev_i_d = cur_i;
                prev_q_d = cur_q;
            end
        end
    end

    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_start_q, s1_start_d;
    logic                     s1_end_q, s1_end_d;
    logic                     s1_out_q, s1_out_d;
    logic signed [PROD_W-1:0] prod_a_q, prod_a_d;
    logic signed [PROD_W-1:0] prod_b_q, prod_b_d;
    logic                     s2_valid_q, s2_valid_d;
    logic                     s2_start_q, s2_start_d;
    logic                     s2_end_q, s2_end_d;
    logic                     s2_out_q, s2_out_d;
    logic signed [WIDTH-1:0]  disc_q, disc_d;
    logic signed [DIFF_W-1:0] diff;
    logic                     s3_start_q, s3_start_d;
    logic                     s3_end_q, s3_end_d;
    logic                     s3_out_q, s3_out_d;
    logic signed [WIDTH-1:0]  hold_q, hold_d;

    logic signed [WIDTH-1:0]  avg_data;
    logic                     avg_valid;
    logic                     out_valid;

    // Pipeline next-state. Flags travel with their sample; stage 3 flags are
    // only raised for tagged-valid samples so reset-cleared stages stay quiet.
    always_comb begin
        s1_valid_d = take;
        s1_start_d = start;
        s1_end_d   = fin;
        s1_out_d   = out_en;
        prod_a_d   = PROD_W'(op_i) * PROD_W'(cur_q);
        prod_b_d   = PROD_W'(cur_i) * PROD_W'(op_q);

        s2_valid_d = s1_valid_q;
        s2_start_d = s1_start_q;
        s2_end_d   = s1_end_q;
        s2_out_d   = s1_out_q;
        diff       = DIFF_W'(prod_a_q) - DIFF_W'(prod_b_q);
        disc_d     = WIDTH'(sat_shift(SAT_MAX_W'(diff), DIFF_W, WIDTH - 1, WIDTH));

        s3_start_d = s2_valid_q & s2_start_q;
        s3_end_d   = s2_valid_q & s2_end_q;
        s3_out_d   = s2_valid_q & s2_out_q;

        hold_d     = out_valid ? avg_data : hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            zero_cnt_q <= '0;
            prev_i_q   <= '0;
            prev_q_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_start_q <= 1'b0;
            s1_end_q   <= 1'b0;
            s1_out_q   <= 1'b0;
            prod_a_q   <= '0;
            prod_b_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_start_q <= 1'b0;
            s2_end_q   <= 1'b0;
            s2_out_q   <= 1'b0;
            disc_q     <= '0;
            s3_start_q <= 1'b0;
            s3_end_q   <= 1'b0;
            s3_out_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            zero_cnt_q <= zero_cnt_d;
            prev_i_q   <= prev_i_d;
            prev_q_q   <= prev_q_d;
            s1_valid_q <= s1_valid_d;
            s1_start_q <= s1_start_d;
            s1_end_q   <= s1_end_d;
            s1_out_q   <= s1_out_d;
            prod_a_q   <= prod_a_d;
            prod_b_q   <= prod_b_d;
            s2_valid_q <= s2_valid_d;
            s2_start_q <= s2_start_d;
            s2_end_q   <= s2_end_d;
            s2_out_q   <= s2_out_d;
            disc_q     <= disc_d;
            s3_start_q <= s3_start_d;
            s3_end_q   <= s3_end_d;
            s3_out_q   <= s3_out_d;
            hold_q     <= hold_d;
        end
    end

    // The averager is cleared by the packet's first sample itself. That sample
    // is dropped by the clear, which is harmless: its value is zero and the
    // slot it would have filled is already zero.
    moving_avg_pow2 #(
        .WIDTH    (WIDTH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (s2_valid_q & s2_start_q),
        .valid_i (s2_valid_q),
        .data_i  (disc_q),
        .data_o  (avg_data),
        .valid_o (avg_valid)
    );

    // data_o shows the fresh average on valid_o cycles and otherwise repeats
    // the last published value, hiding the averager's movement during fill.
    assign out_valid       = avg_valid & s3_out_q;
    assign bus.valid_o     = out_valid;
    assign bus.data_o      = hold_d;
    assign bus.pkt_start_o = s3_start_q;
    assign bus.pkt_end_o   = s3_end_q;

endmodule

// File: tb/tb_fm_demod_stream.sv
// tb_fm_demod_stream: directed scoreboard bench for fm_demod_stream.
// dut_a uses AVG_LOG2=2 and dut_b uses AVG_LOG2=0, both WIDTH=16, IDLE_LEN=4.
// Stimulus pushes hand-computed expected outputs (with their due cycle) into
// per-DUT queues; negedge monitors pop and compare whenever a DUT emits.
module tb_fm_demod_stream;

    typedef struct {
        int cyc;
        bit v;
        int data;
        bit s;
        bit e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    exp_t qa[$];
    exp_t qb[$];

    int rot_i[4] = '{16384, 0, -16384, 0};
    int rot_q[4] = '{0, 16384, 0, -16384};
    int tail[4]  = '{6144, 4096, 2048, 0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fm_demod_stream_if #(.WIDTH(16)) bus_a ();
    fm_demod_stream_if #(.WIDTH(16)) bus_b ();

    fm_demod_stream #(.WIDTH(16), .AVG_LOG2(2), .IDLE_LEN(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fm_demod_stream #(.WIDTH(16), .AVG_LOG2(0), .IDLE_LEN(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Drive one valid sample in the next cycle and record what must appear
    // three cycles later (nothing is recorded for silent fill samples).
    task automatic applyStimulus(input int sel, input int i_val, input int q_val,
                                 input bit ev, input int ed, input bit es, input bit ee);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel == 0) begin
            bus_a.data_i  = {16'(i_val), 16'(q_val)};
            bus_a.valid_i = 1'b1;
        end else begin
            bus_b.data_i  = {16'(i_val), 16'(q_val)};
            bus_b.valid_i = 1'b1;
        end
        e.cyc  = cyc + 3;
        e.v    = ev;
        e.data = ed;
        e.s    = es;
        e.e    = ee;
        if (ev || es || ee) begin
            if (sel == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            bus_a.valid_i = 1'b0;
            bus_a.data_i  = '0;
            bus_b.valid_i = 1'b0;
            bus_b.data_i  = '0;
        end
    endtask

    // Pop the next expected event for a DUT and compare it with what it emits.
    task automatic checkOutput(input int sel);
        exp_t e;
        bit   v, s, en, empty;
        int   d;
        if (sel == 0) begin
            v = bus_a.valid_o; s = bus_a.pkt_start_o; en = bus_a.pkt_end_o;
            d = int'($signed(bus_a.data_o));
            empty = (qa.size() == 0);
        end else begin
            v = bus_b.valid_o; s = bus_b.pkt_start_o; en = bus_b.pkt_end_o;
            d = int'($signed(bus_b.data_o));
            empty = (qb.size() == 0);
        end
        checks++;
        if (empty) begin
            errors++;
            $display("[TB] FAIL unexpected_output dut%0d cyc=%0d got v=%0d d=%0d s=%0d e=%0d, required no output",
                     sel, cyc, v, d, s, en);
            return;
        end
        if (sel == 0) e = qa.pop_front();
        else e = qb.pop_front();
        if (e.cyc != cyc || e.v != v || e.s != s || e.e != en || (e.v && e.data != d)) begin
            errors++;
            $display("[TB] FAIL output dut%0d got cyc=%0d v=%0d d=%0d s=%0d e=%0d, required cyc=%0d v=%0d d=%0d s=%0d e=%0d",
                     sel, cyc, v, d, s, en, e.cyc, e.v, e.data, e.s, e.e);
        end
    endtask

    task automatic checkZero(input string name, input int sel);
        logic [15:0] d;
        logic        v, s, en;
        if (sel == 0) begin
            d = bus_a.data_o; v = bus_a.valid_o; s = bus_a.pkt_start_o; en = bus_a.pkt_end_o;
        end else begin
            d = bus_b.data_o; v = bus_b.valid_o; s = bus_b.pkt_start_o; en = bus_b.pkt_end_o;
        end
        checks++;
        if (d !== 16'd0) begin
            errors++;
            $display("[TB] FAIL %s_data got %0h, required 0", name, d);
        end
        checks++;
        if ({v, s, en} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL %s_flags got v/s/e=%b, required 000", name, {v, s, en});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (bus_a.valid_o || bus_a.pkt_start_o || bus_a.pkt_end_o)) checkOutput(0);
    end

    always @(negedge clk) begin
        if (mon_en && (bus_b.valid_o || bus_b.pkt_start_o || bus_b.pkt_end_o)) checkOutput(1);
    end

    initial begin
        int r;
        bus_a.valid_i = 1'b0;
        bus_a.data_i  = '0;
        bus_b.valid_i = 1'b0;
        bus_b.data_i  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkZero("reset_a", 0);
        checkZero("reset_b", 1);
        mon_en = 1'b1;

        $display("[TB] constant tone");
        for (int n = 0; n < 8; n++) applyStimulus(0, 16384, 0, n >= 3, 0, n == 0, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 1'b1, 0, 1'b0, n == 3);

        $display("[TB] rotation, end, ignored zero, restart");
        for (int n = 0; n < 8; n++)
            applyStimulus(0, rot_i[n % 4], rot_q[n % 4], n >= 3, (n == 3) ? 6144 : 8192, n == 0, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 1'b1, tail[n], 1'b0, n == 3);
        applyStimulus(0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(0, 16384, 0, n == 3, 0, n == 0, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 1'b1, 0, 1'b0, n == 3);
        quiet(2);

        $display("[TB] gapped rotation");
        for (int n = 0; n < 8; n++) begin
            applyStimulus(0, rot_i[n % 4], rot_q[n % 4], n >= 3, (n == 3) ? 6144 : 8192, n == 0, 1'b0);
            quiet(1);
        end
        for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 1'b1, tail[n], 1'b0, n == 3);
        quiet(2);

        $display("[TB] reset mid-packet");
        for (int n = 0; n < 6; n++)
            applyStimulus(0, rot_i[n % 4], rot_q[n % 4], n >= 3, (n == 3) ? 6144 : 8192, n == 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_a.valid_i = 1'b0;
        bus_a.data_i  = '0;
        r = cyc;
        while (qa.size() > 0 && qa[$].cyc > r) void'(qa.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkZero("midreset_a", 0);
        for (int n = 0; n < 4; n++) applyStimulus(0, 16384, 0, n == 3, 0, n == 0, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 1'b1, 0, 1'b0, n == 3);
        quiet(2);

        $display("[TB] saturation without averaging");
        applyStimulus(1, -32768, 0, 1'b1, 0, 1'b1, 1'b0);
        applyStimulus(1, 0, -32768, 1'b1, 32767, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus(1, 0, 0, 1'b1, 0, 1'b0, n == 3);
        quiet(10);

        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_a got %0d outstanding, required 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_b got %0d outstanding, required 0", qb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
